// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and long-latency results onto one RegFile write port
module writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_wa,
    input  logic [31:0] alu_wd,
    output logic        alu_stall,
    input  logic        ext_valid,
    output logic        ext_ready,
    input  logic [4:0]  ext_wa,
    input  logic [31:0] ext_wd,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]    wa_mem   [DEPTH];
    logic [31:0]   wd_mem   [DEPTH];
    logic [DEPTH-1:0] kill_mem;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;

    logic fifo_empty;
    logic grant_alu;
    logic grant_fifo;
    logic push;
    logic push_kill;
    logic kill_en;
    logic [SW-1:0] starve_inc;

    // Grant decision and FIFO handshake; ext_ready uses registered occupancy only
    always_comb begin
        fifo_empty = (count == '0);
        ext_ready  = !rst && (count < DEPTH_C);
        grant_alu  = !alu_stall && alu_valid;
        grant_fifo = !grant_alu && !fifo_empty;
        push       = ext_valid && ext_ready && (ext_wa != 5'd0);
        kill_en    = grant_alu && (alu_wa != 5'd0);
        push_kill  = kill_en && (ext_wa == alu_wa);
        starve_inc = starve + 1'b1;
    end

    // FIFO payload storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            wa_mem[wr_ptr] <= ext_wa;
            wd_mem[wr_ptr] <= ext_wd;
        end
    end

    // FIFO control, WAW kill flags, starvation tracking and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            kill_mem  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            starve    <= '0;
            alu_stall <= 1'b0;
            we        <= 1'b0;
            wa        <= 5'd0;
            wd        <= 32'd0;
        end else begin
            // A younger ALU write to the same register makes queued results dead
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (wa_mem[i] == alu_wa)) begin
                    kill_mem[i] <= 1'b1;
                end
            end
            if (push) begin
                kill_mem[wr_ptr] <= push_kill;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (grant_fifo) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !grant_fifo) begin
                count <= count + 1'b1;
            end else if (!push && grant_fifo) begin
                count <= count - 1'b1;
            end

            // Head loses to ALU: count; a pop or an empty FIFO restarts the count
            alu_stall <= 1'b0;
            if (grant_alu && !fifo_empty) begin
                if (starve_inc == LIMIT_C) begin
                    starve    <= '0;
                    alu_stall <= 1'b1;
                end else begin
                    starve <= starve_inc;
                end
            end else begin
                starve <= '0;
            end

            // Write port: killed heads and r0 writes consume the slot without writing
            we <= 1'b0;
            if (grant_alu) begin
                if (alu_wa != 5'd0) begin
                    we <= 1'b1;
                    wa <= alu_wa;
                    wd <= alu_wd;
                end
            end else if (grant_fifo) begin
                if (!kill_mem[rd_ptr]) begin
                    we <= 1'b1;
                    wa <= wa_mem[rd_ptr];
                    wd <= wd_mem[rd_ptr];
                end
            end
        end
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: entries in the long-latency write FIFO (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 8: consecutive lost grants before the FIFO head forces a slot.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 alu_valid  input  1  single-cycle ALU result present this cycle.
REQ-006 alu_wa  input  5  ALU destination register.
REQ-007 alu_wd  input  32  ALU write data.
REQ-008 alu_stall  output  1  registered; upstream holds alu_valid/alu_wa/alu_wd stable while high.
REQ-009 ext_valid  input  1  long-latency (load/mul/div) result offered.
REQ-010 ext_ready  output  1  FIFO can accept; transfer when ext_valid && ext_ready.
REQ-011 ext_wa  input  5  long-latency destination register.
REQ-012 ext_wd  input  32  long-latency write data.
REQ-013 we  output  1  registered write enable to RegFile we.
REQ-014 wa  output  5  registered write address to RegFile wa.
REQ-015 wd  output  32  registered write data to RegFile wd.

Function
REQ-016 Block SHALL merge both result streams onto the single RegFile write port, at most one write per cycle.
REQ-017 ext_ready SHALL equal (FIFO occupancy < DEPTH), from registered occupancy only; no same-cycle pop credit.
REQ-018 Accepted ext result with ext_wa==0 SHALL be discarded, not pushed.
REQ-019 Grant per cycle: if alu_stall==0 and alu_valid==1 -> ALU; else if FIFO non-empty -> FIFO head; else none.
REQ-020 ALU grant with alu_wa!=0: next cycle we=1, wa=alu_wa, wd=alu_wd (latency 1).
REQ-021 ALU grant with alu_wa==0: next cycle we=0; grant still consumed.
REQ-022 FIFO grant pops head; live head -> next cycle we=1, wa/wd = head; killed head -> we=0, slot consumed.
REQ-023 No bypass: ext result accepted at edge N earliest appears on we/wa/wd after edge N+1.
REQ-024 Cycle with no grant: we=0; wa/wd hold previous values.
REQ-025 WAW kill: ALU grant with alu_wa=X!=0 SHALL mark killed every stored FIFO entry with wa==X, and an entry pushed in the same cycle with ext_wa==X.
REQ-026 Simultaneous push and pop SHALL keep occupancy unchanged; FIFO order strictly preserved; pointers wrap modulo DEPTH.
REQ-027 Starve counter: +1 each cycle FIFO non-empty and ALU wins grant; cleared on any FIFO pop or when FIFO empty.
REQ-028 When counter reaches STARVE_LIMIT, alu_stall SHALL be 1 for exactly the next cycle; counter clears.
REQ-029 While alu_stall==1, FIFO head SHALL receive grant; ALU inputs ignored (held upstream, serviced next cycle); no kill from ignored ALU input.
REQ-030 If FIFO drains before alu_stall cycle (killed head still counts as non-empty), alu_stall still asserts one cycle with we=0.

Reset
REQ-031 rst high at an edge SHALL set: we=0, wa=0, wd=0, alu_stall=0, occupancy 0, all kill flags 0, starve counter 0, pointers 0.
REQ-032 ext_ready SHALL be 0 while rst is high; 1 on first cycle after release.
REQ-033 Reset mid-operation SHALL discard all FIFO contents; no pending writes emitted afterwards.

Verification
REQ-034 Reset, then alu_valid=1, alu_wa=5, alu_wd=0xA5A5A5A5 one cycle -> next cycle we=1, wa=5, wd=0xA5A5A5A5; following cycle we=0.
REQ-035 Idle ALU, push ext (wa=3, wd=3) at edge N -> we=1, wa=3, wd=3 after edge N+1; ext_ready stays 1.
REQ-036 Push 4 ext entries with alu_valid held 1 (wa!=ext addresses) -> ext_ready=0 after 4th push; 5th ext_valid not accepted; after 8 lost grants alu_stall=1 one cycle and oldest entry written.
REQ-037 Push ext (wa=7, wd=1), then ALU write wa=7, wd=2 before pop -> RegFile sees only wd=2 to r7; FIFO slot popped with we=0.
REQ-038 ext_wa=0 and alu_wa=0 inputs -> we never asserts; occupancy stays 0.
REQ-039 Fill FIFO with 3 entries, assert rst one cycle -> we=0 thereafter, ext_ready=1 after release, no stale write appears.
